tx_write_sequencer: RTL and testbench

- Sequences one register-write command into three byte transactions on the single-byte serial transmitter: device-address byte, register-address byte, data byte.
- Sits between IMU control logic (command source) and the transmitter.
- Handles the transmitter's send_en/is_busy handshake, inter-byte gaps and start-acknowledge timeout.
- Reports completion or error per command.

---
 rtl/tx_write_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tx_write_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_write_sequencer.sv
// tx_write_sequencer: splits one register-write command into dev-addr, reg-addr and data byte transfers.
// Optional macro TX_SEQ_RETRY_EN: retries timed-out bytes up to MAX_RETRY times and adds retry_cnt.
`default_nettype none

module tx_write_sequencer #(
   parameter int BUS_WIDTH   = 8,
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 8,
   parameter int MAX_RETRY   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [BUS_WIDTH-2:0] cmd_dev_addr,
   input  logic [BUS_WIDTH-1:0] cmd_reg_addr,
   input  logic [BUS_WIDTH-1:0] cmd_data,
   output logic [BUS_WIDTH-1:0] tx_data,
   output logic                 tx_is_addr,
   output logic                 tx_send_en,
   input  logic                 tx_busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           byte_idx
`ifdef TX_SEQ_RETRY_EN
   ,
   output logic [1:0]           retry_cnt
`endif
);

   localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4,
      S_DONE      = 3'd5,
      S_FAIL      = 3'd6
   } state_t;

   // With no inter-byte gap the next byte is issued straight away.
   localparam state_t AFTER_BYTE = (GAP_CYCLES == 0) ? S_ISSUE : S_GAP;

   state_t               state, next_state;
   logic [BUS_WIDTH-1:0] dev_byte, reg_byte, data_byte, cur_byte;
   logic [ACK_W-1:0]     ack_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic                 accept, timeout, byte_ok, can_retry, active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      cmd_ready  = 1'b0;
      tx_send_en = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      timeout    = 1'b0;
      byte_ok    = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) next_state = S_ISSUE;
         end
         S_ISSUE: begin
            if (!tx_busy) begin
               tx_send_en = 1'b1;
               next_state = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (tx_busy) begin
               next_state = S_WAIT_DONE;
            end else if (ack_cnt == ACK_LAST) begin
               timeout    = 1'b1;
               next_state = can_retry ? AFTER_BYTE : S_FAIL;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               byte_ok    = 1'b1;
               next_state = (byte_idx == 2'd2) ? S_DONE : AFTER_BYTE;
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) next_state = S_ISSUE;
         end
         S_DONE: begin
            done       = 1'b1;
            cmd_ready  = 1'b1;
            next_state = cmd_valid ? S_ISSUE : S_IDLE;
         end
         S_FAIL: begin
            error      = 1'b1;
            cmd_ready  = 1'b1;
            next_state = cmd_valid ? S_ISSUE : S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dev_byte  <= '0;
         reg_byte  <= '0;
         data_byte <= '0;
         byte_idx  <= 2'd0;
         ack_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         if (accept) begin
            dev_byte  <= {cmd_dev_addr, 1'b0};
            reg_byte  <= cmd_reg_addr;
            data_byte <= cmd_data;
            byte_idx  <= 2'd0;
         end else if (byte_ok && byte_idx != 2'd2) begin
            byte_idx <= byte_idx + 2'd1;
         end else if (state == S_DONE || state == S_FAIL) begin
            byte_idx <= 2'd0;
         end

         if (state != S_WAIT_ACK)     ack_cnt <= '0;
         else if (ack_cnt != ACK_LAST) ack_cnt <= ack_cnt + 1'b1;

         if (state != S_GAP)          gap_cnt <= '0;
         else if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
      end
   end

`ifdef TX_SEQ_RETRY_EN
   logic [1:0] retry_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      retry_q <= 2'd0;
      else if (accept || byte_ok)   retry_q <= 2'd0;
      else if (timeout && can_retry) retry_q <= retry_q + 2'd1;
   end

   assign can_retry = (retry_q < 2'(MAX_RETRY));
   assign retry_cnt = retry_q;
`else
   assign can_retry = 1'b0;
`endif

   always_comb begin
      cur_byte = data_byte;
      case (byte_idx)
         2'd0:    cur_byte = dev_byte;
         2'd1:    cur_byte = reg_byte;
         default: cur_byte = data_byte;
      endcase
   end

   // Byte and is_addr are held for the whole transaction because the transmitter keeps sampling them.
   assign active     = (state == S_ISSUE) || (state == S_WAIT_ACK) || (state == S_WAIT_DONE);
   assign tx_data    = active ? cur_byte : '0;
   assign tx_is_addr = active && (byte_idx == 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_tx_write_sequencer.sv
// tb_tx_write_sequencer: randomized commands against a cycle-accurate timing model of the write sequence.
`default_nettype none

module tb_tx_write_sequencer;

   localparam int GAP  = 4;
   localparam int TMO  = 8;
   localparam int MAXR = 2;
`ifdef TX_SEQ_RETRY_EN
   localparam int ATTEMPTS = MAXR + 1;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, tx_busy = 1'b0;
   logic       cmd_ready, tx_is_addr, tx_send_en, done, error;
   logic [6:0] cmd_dev_addr = '0;
   logic [7:0] cmd_reg_addr = '0, cmd_data = '0, tx_data;
   logic [1:0] byte_idx;
`ifdef TX_SEQ_RETRY_EN
   logic [1:0] retry_cnt;
`endif

   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   tx_write_sequencer #(.BUS_WIDTH(8), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
      .tx_data(tx_data), .tx_is_addr(tx_is_addr), .tx_send_en(tx_send_en), .tx_busy(tx_busy),
      .done(done), .error(error), .byte_idx(byte_idx)
`ifdef TX_SEQ_RETRY_EN
      , .retry_cnt(retry_cnt)
`endif
   );

   typedef struct {
      logic [6:0] dev;
      logic [7:0] rg;
      logic [7:0] dat;
      int         drop_byte;
      int         drops;
      int         pre;
      bit         do_rst;
      bit         chain;
   } cmd_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic apply(input cmd_t c);
      cmd_valid    = 1'b1;
      cmd_dev_addr = c.dev;
      cmd_reg_addr = c.rg;
      cmd_data     = c.dat;
   endtask

   // Called with the command already on the inputs; the next clock edge accepts it (cycle 0).
   task automatic run_cmd(input cmd_t c, input bit has_next, input cmd_t nx);
      int         e_send[12], e_try[12], e_idx[12], dl[12], ln[12];
      logic [7:0] e_byte[12];
      bit         e_addr[12], dropped[12];
      logic [7:0] bytes[3];
      int         t, f, n, term, err_idx, rst_cyc, k, sent, win_lo, win_hi, a;
      bit         exp_err, stop;

      bytes[0] = {c.dev, 1'b0};
      bytes[1] = c.rg;
      bytes[2] = c.dat;
      t = 1 + c.pre; n = 0; term = 0; f = 0; exp_err = 0; err_idx = 0; stop = 0;
      for (int b = 0; b < 3 && !stop; b++) begin
         for (int tr = 0; tr < ATTEMPTS; tr++) begin
            a = n;
            e_send[a] = t; e_byte[a] = bytes[b]; e_addr[a] = (b == 0); e_try[a] = tr; e_idx[a] = b;
            dl[a] = $urandom_range(1, 4);
            ln[a] = $urandom_range(2, 5);
            dropped[a] = (b == c.drop_byte) && (tr < c.drops);
            n++;
            if (!dropped[a]) begin
               f = t + dl[a] + ln[a];
               t = f + GAP + 1;
               term = f + 1;
               break;
            end else if (tr == ATTEMPTS - 1) begin
               term = t + TMO + 1; exp_err = 1; err_idx = b; stop = 1;
            end else begin
               t = t + TMO + GAP + 1;
            end
         end
      end
      rst_cyc = c.do_rst ? e_send[n-1] + dl[n-1] + 1 : -1;

      sent = 0; win_lo = 0; win_hi = -1;
      @(posedge clk);
      k = 1;
      while (1) begin
         #1 tx_busy = (k <= c.pre) || (k >= win_lo && k <= win_hi);
         #1;
         check("done_error_excl", {31'b0, done & error}, 0);
         if (tx_send_en) begin
            if (sent < n) begin
               check("send_cycle", k, e_send[sent]);
               check("send_data", tx_data, e_byte[sent]);
               check("send_is_addr", tx_is_addr, e_addr[sent]);
               check("send_byte_idx", byte_idx, e_idx[sent]);
`ifdef TX_SEQ_RETRY_EN
               check("retry_cnt", retry_cnt, e_try[sent]);
`endif
               if (!dropped[sent]) begin
                  win_lo = k + dl[sent];
                  win_hi = win_lo + ln[sent] - 1;
               end
            end else begin
               check("extra_send", sent, n);
            end
            sent++;
         end else if (tx_busy && sent > 0 && sent <= n) begin
            check("hold_data", tx_data, e_byte[sent-1]);
            check("hold_is_addr", tx_is_addr, e_addr[sent-1]);
         end

         if (k == rst_cyc) begin
            rst = 1'b1; tx_busy = 1'b0; cmd_valid = 1'b0;
            #1;
            check("rst_ready", cmd_ready, 1);
            check("rst_send_en", tx_send_en, 0);
            check("rst_is_addr", tx_is_addr, 0);
            check("rst_tx_data", tx_data, 0);
            check("rst_byte_idx", byte_idx, 0);
            @(posedge clk); #2;
            check("rst_no_done", done, 0);
            check("rst_no_error", error, 0);
            rst = 1'b0;
            return;
         end

         if (done || error) begin
            check("term_cycle", k, term);
            check("term_error", error, exp_err);
            check("term_done", done, !exp_err);
            if (exp_err) check("err_byte_idx", byte_idx, err_idx);
            check("ready_at_term", cmd_ready, 1);
            check("send_count", sent, n);
            if (c.chain && has_next) apply(nx);
            else cmd_valid = 1'b0;
            return;
         end
         check("ready_low", cmd_ready, 0);
         if (k > term + 3) begin
            check("term_missing", k, term);
            cmd_valid = 1'b0;
            return;
         end
         // Junk requests while busy must be ignored.
         cmd_valid    = 1'($urandom_range(0, 1));
         cmd_dev_addr = 7'($urandom);
         cmd_reg_addr = 8'($urandom);
         cmd_data     = 8'($urandom);
         @(posedge clk);
         k++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t q[$];
      cmd_t c;

      repeat (3) @(posedge clk);
      #2;
      check("reset_ready", cmd_ready, 1);
      check("reset_send_en", tx_send_en, 0);
      check("reset_is_addr", tx_is_addr, 0);
      check("reset_tx_data", tx_data, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);
      check("reset_byte_idx", byte_idx, 0);
`ifdef TX_SEQ_RETRY_EN
      check("reset_retry_cnt", retry_cnt, 0);
`endif
      rst = 1'b0;

      q.push_back('{7'h68, 8'h6B, 8'h00, -1, 0, 0, 1'b0, 1'b1});
      q.push_back('{7'h68, 8'h6B, 8'h00, 1, ATTEMPTS, 0, 1'b0, 1'b1});
      q.push_back('{7'h2A, 8'h10, 8'hA5, -1, 0, 3, 1'b0, 1'b0});
      q.push_back('{7'h55, 8'h3C, 8'hC3, -1, 0, 0, 1'b1, 1'b0});
      q.push_back('{7'h11, 8'h22, 8'h33, 0, ATTEMPTS - 1, 0, 1'b0, 1'b1});
      for (int i = 0; i < 24; i++) begin
         c.dev = 7'($urandom); c.rg = 8'($urandom); c.dat = 8'($urandom);
         c.drop_byte = -1; c.drops = 0;
         c.pre = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         if ($urandom_range(0, 3) == 0) begin
            c.drop_byte = $urandom_range(0, 2);
            c.drops     = $urandom_range(1, ATTEMPTS);
         end
         c.do_rst = (c.drop_byte < 0) && ($urandom_range(0, 9) == 0);
         c.chain  = 1'($urandom_range(0, 1));
         q.push_back(c);
      end

      for (int i = 0; i < q.size(); i++) begin
         if (i == 0 || !q[i-1].chain || q[i-1].do_rst) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            check("ready_idle", cmd_ready, 1);
            apply(q[i]);
         end
         run_cmd(q[i], (i + 1 < q.size()), (i + 1 < q.size()) ? q[i+1] : q[i]);
      end

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
